float_byte_tx: RTL and testbench

- Serializer for the result side of the floating-point multiplier datapath.
- Accepts one 32-bit IEEE-754 single-precision word plus its 2-bit special-case code through a valid/ready load port.
- Emits the word as a sequence of bytes on a valid/ready byte port.
- This is the counterpart of the byte-wise operand loader: bytes go out in the same order and with the same indexing the loader uses to accept them.

---
 rtl/fp_io_pkg.sv | 10 +
 rtl/fp_special_sub.sv | 19 +
 rtl/float_byte_tx.sv | 103 ++++++++++
 tb/tb_float_byte_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp_io_pkg.sv
// fp_io_pkg: shared states and IEEE-754 special-case constants for the fp multiplier I/O path
package fp_io_pkg;
  typedef enum logic [1:0] {IDLE, HDR, SEND} tx_state_t;
  localparam logic [1:0] SPEC_NORMAL = 2'b00;
  localparam logic [1:0] SPEC_NAN = 2'b01;
  localparam logic [1:0] SPEC_INF = 2'b11;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;
  localparam logic [3:0] HDR_TAG = 4'hC;
endpackage

// File: rtl/fp_special_sub.sv
// fp_special_sub: replaces a word by quiet NaN or signed infinity according to its special code
module fp_special_sub
  import fp_io_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_word,
  input  logic [1:0]   i_special,
  output logic [W-1:0] o_word
);
  generate
    if (W == 32) begin : g_ieee
      always_comb o_word = i_special == SPEC_NAN ? FP_QNAN :
                           i_special == SPEC_INF ? {i_word[31], FP_INF_MAG} : i_word;
    end else begin : g_raw
      assign o_word = i_word;
    end
  endgenerate
endmodule

// File: rtl/float_byte_tx.sv
// float_byte_tx: serializes one float result word into a valid/ready byte stream
// FLOAT_BYTE_TX_HEADER_EN prepends a {C,00,special} header byte with index 7
module float_byte_tx
  import fp_io_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic [1:0]            in_special,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic [2:0]            tx_index,
  output logic                  tx_last,
  output logic                  busy
);
  localparam int W = 8 * NBYTES;
  tx_state_t r_state;
  logic [W-1:0] r_word;
  logic [2:0] r_cnt;
  logic r_valid;
  logic [7:0] r_data;
  logic [2:0] r_idx;
  logic r_last;
  logic [W-1:0] w_word;
`ifdef FLOAT_BYTE_TX_HEADER_EN
  logic [1:0] r_spec;
`endif
  fp_special_sub #(.W(W)) u_special (.i_word(in_data), .i_special(in_special), .o_word(w_word));
  // sequence position -> logical byte number
  function automatic logic [2:0] lidx(input logic [2:0] p);
    return LSB_FIRST ? p : 3'(NBYTES - 1) - p;
  endfunction
  function automatic logic [7:0] pick(input logic [W-1:0] w, input logic [2:0] p);
    return w[8*lidx(p) +: 8];
  endfunction
  assign in_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign tx_valid = r_valid;
  assign tx_data = r_data;
  assign tx_index = r_idx;
  assign tx_last = r_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word <= '0;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_idx <= '0;
      r_last <= 1'b0;
`ifdef FLOAT_BYTE_TX_HEADER_EN
      r_spec <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_word <= w_word;
          r_cnt <= '0;
          r_valid <= 1'b1;
`ifdef FLOAT_BYTE_TX_HEADER_EN
          r_spec <= in_special;
          r_state <= HDR;
          r_data <= {HDR_TAG, 2'b00, in_special};
          r_idx <= 3'd7;
          r_last <= 1'b0;
`else
          r_state <= SEND;
          r_data <= pick(w_word, 3'd0);
          r_idx <= lidx(3'd0);
          r_last <= NBYTES == 1;
`endif
        end
`ifdef FLOAT_BYTE_TX_HEADER_EN
        HDR: if (tx_ready) begin
          r_state <= SEND;
          r_data <= pick(r_word, 3'd0);
          r_idx <= lidx(3'd0);
          r_last <= NBYTES == 1;
        end
`endif
        SEND: if (tx_ready) begin
          if (r_last) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            r_data <= pick(r_word, r_cnt + 3'd1);
            r_idx <= lidx(r_cnt + 3'd1);
            r_last <= r_cnt + 3'd1 == 3'(NBYTES - 1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_byte_tx.sv
// tb_float_byte_tx: LSB-first and MSB-first instances checked against a byte-queue model
module tb_float_byte_tx;
`ifdef FLOAT_BYTE_TX_HEADER_EN
  localparam int HD = 1;
`else
  localparam int HD = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, tx_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0] in_special = '0;
  logic l_in_ready, l_valid, l_last, l_busy, m_in_ready, m_valid, m_last, m_busy;
  logic [7:0] l_data, m_data;
  logic [2:0] l_idx, m_idx;
  int n_chk = 0, n_fail = 0;
  bit armed = 0;
  logic [11:0] ql[$], qm[$], logl[$], logm[$];
  logic [7:0] hdr_l = '0;
  always #5 clk = ~clk;
  float_byte_tx dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .in_special(in_special), .tx_valid(l_valid), .tx_ready(tx_ready), .tx_data(l_data),
    .tx_index(l_idx), .tx_last(l_last), .busy(l_busy));
  float_byte_tx #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .in_special(in_special), .tx_valid(m_valid), .tx_ready(tx_ready), .tx_data(m_data),
    .tx_index(m_idx), .tx_last(m_last), .busy(m_busy));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: each load becomes the list of {last, index, byte} the frame must carry
  task automatic push_frame(input logic [31:0] d, input logic [1:0] s);
    logic [31:0] w;
    w = s == 2'b01 ? 32'h7FC0_0000 : s == 2'b11 ? {d[31], 31'h7F80_0000} : d;
    if (HD == 1) begin
      ql.push_back({1'b0, 3'd7, 4'hC, 2'b00, s});
      qm.push_back({1'b0, 3'd7, 4'hC, 2'b00, s});
    end
    for (int i = 0; i < 4; i++) begin
      ql.push_back({i == 3, 3'(i), w[8*i +: 8]});
      qm.push_back({i == 3, 3'(3 - i), w[8*(3-i) +: 8]});
    end
  endtask
  always @(posedge clk) begin
    bit e;
    if (rst) begin
      ql.delete();
      qm.delete();
    end else begin
      e = ql.size() == 0;
      if (tx_ready && ql.size() != 0) void'(ql.pop_front());
      if (tx_ready && qm.size() != 0) void'(qm.pop_front());
      if (in_valid && e) push_frame(in_data, in_special);
      if (armed && l_valid && tx_ready) begin
        if (l_idx == 3'd7) hdr_l <= l_data;
        else logl.push_back({l_last, l_idx, l_data});
      end
      if (armed && m_valid && tx_ready && m_idx != 3'd7) logm.push_back({m_last, m_idx, m_data});
    end
  end
  always @(negedge clk) if (armed) begin
    chk("l_valid", l_valid, ql.size() != 0);
    chk("l_in_ready", l_in_ready, ql.size() == 0);
    chk("l_busy", l_busy, ql.size() != 0);
    if (ql.size() != 0) chk("l_byte", {l_last, l_idx, l_data}, ql[0]);
    chk("m_valid", m_valid, qm.size() != 0);
    chk("m_in_ready", m_in_ready, qm.size() == 0);
    chk("m_busy", m_busy, qm.size() != 0);
    if (qm.size() != 0) chk("m_byte", {m_last, m_idx, m_data}, qm[0]);
  end
  task automatic load(input logic [31:0] d, input logic [1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!l_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("load_wait", n < 50, 1);
    logl.delete();
    logm.delete();
    in_valid = 1'b1;
    in_data = d;
    in_special = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!l_in_ready && n < 50);
    chk("idle_timeout", n < 50, 1);
  endtask
  // b0..b3 are logical bytes 0..3 of the expected word
  task automatic cmp_log(input string nm, input logic [7:0] b0, b1, b2, b3);
    logic [7:0] b[4];
    b = '{b0, b1, b2, b3};
    chk({nm, "_lcount"}, logl.size(), 4);
    chk({nm, "_mcount"}, logm.size(), 4);
    for (int i = 0; i < 4 && i < logl.size(); i++)
      chk({nm, "_lsb"}, logl[i], {i == 3, 3'(i), b[i]});
    for (int i = 0; i < 4 && i < logm.size(); i++)
      chk({nm, "_msb"}, logm[i], {i == 3, 3'(3 - i), b[3-i]});
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", l_valid, 0);
    chk("rst_data", l_data, 0);
    chk("rst_index", l_idx, 0);
    chk("rst_last", l_last, 0);
    chk("rst_busy", l_busy, 0);
    chk("rst_in_ready", l_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    armed = 1;
    load(32'h4049_0FDB, 2'b00);
    wait_idle(n);
    chk("frame_len", n, 5 + HD);
    cmp_log("normal", 8'hDB, 8'h0F, 8'h49, 8'h40);
    load(32'h4049_0FDB, 2'b00);
    repeat (2 + HD) @(negedge clk);
    tx_ready = 1'b0;
    repeat (3) begin
      chk("stall_l", {l_valid, l_idx, l_data}, {1'b1, 3'd1, 8'h0F});
      chk("stall_m", {m_valid, m_idx, m_data}, {1'b1, 3'd2, 8'h49});
      @(negedge clk);
    end
    tx_ready = 1'b1;
    wait_idle(n);
    cmp_log("stall", 8'hDB, 8'h0F, 8'h49, 8'h40);
    load(32'h1234_5678, 2'b01);
    wait_idle(n);
    cmp_log("nan", 8'h00, 8'h00, 8'hC0, 8'h7F);
    load(32'h8000_0000, 2'b11);
    wait_idle(n);
    cmp_log("neg_inf", 8'h00, 8'h00, 8'h80, 8'hFF);
    load(32'h0000_0000, 2'b11);
    wait_idle(n);
    cmp_log("pos_inf", 8'h00, 8'h00, 8'h80, 8'h7F);
    if (HD == 1) chk("hdr_byte", hdr_l, 8'hC3);
    load(32'h3F80_0001, 2'b10);
    wait_idle(n);
    cmp_log("code10", 8'h01, 8'h00, 8'h80, 8'h3F);
    load(32'h4049_0FDB, 2'b00);
    repeat (2 + HD) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", l_valid, 0);
    chk("abort_busy", m_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    load(32'hAABB_CCDD, 2'b00);
    wait_idle(n);
    cmp_log("after_abort", 8'hDD, 8'hCC, 8'hBB, 8'hAA);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h1111_2222;
    @(posedge clk);
    #1;
    chk("rst_wins_busy", l_busy, 0);
    chk("rst_wins_valid", m_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
